control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 62 ++++++
 rtl/cu_out_decode.sv | 69 ++++++
 rtl/control_unit.sv | 121 ++++++++++++
 tb/tb_control_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants and types for the control unit: opcodes, state encodings,
// ALU / MDR source codes and the control-signal bundle.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam logic [3:0] ALU_ADD = 4'd2;

  localparam logic [1:0] MDR_BUS = 2'b00;
  localparam logic [1:0] MDR_MEM = 2'b01;
  localparam logic [1:0] MDR_IMM = 2'b10;

  // RST must stay at zero so that present_state reads 0 while in reset
  typedef enum logic [4:0] {
    RST  = 5'd0,
    F0   = 5'd1,
    F1   = 5'd2,
    F2   = 5'd3,
    LDI3 = 5'd4,
    LDI4 = 5'd5,
    LDI5 = 5'd6,
    LD3  = 5'd7,
    LD4  = 5'd8,
    LD5  = 5'd9,
    LD6  = 5'd10,
    LD7  = 5'd11,
    ST3  = 5'd12,
    ST4  = 5'd13,
    ST5  = 5'd14,
    ST6  = 5'd15,
    ST7  = 5'd16,
    HALT = 5'd17
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       mar_in;
    logic       zlow_in;
    logic       pc_in;
    logic       mdr_in;
    logic       read;
    logic       write;
    logic       ir_in;
    logic       y_in;
    logic       inc_pc;
    logic       c_out;
    logic       ba_out;
    logic       r_in;
    logic       r_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic [1:0] mdr_read;
    logic [3:0] control;
  } cu_ctrl_t;

endpackage

// File: rtl/cu_out_decode.sv
// Pure state-to-control decode for the control unit (Moore outputs).
module cu_out_decode
  import cu_pkg::*;
(
  input  state_t   state,
  output cu_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      F0: begin
        ctrl.pc_out  = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.zlow_in = 1'b1;
      end
      F1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        ctrl.mdr_read = MDR_MEM;
      end
      F2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      LD3, LDI3, ST3: begin
        ctrl.grb    = 1'b1;
        ctrl.ba_out = 1'b1;
        ctrl.y_in   = 1'b1;
      end
      LD4, LDI4, ST4: begin
        ctrl.c_out   = 1'b1;
        ctrl.zlow_in = 1'b1;
        ctrl.control = ALU_ADD;
      end
      LDI5: begin
        ctrl.zlow_out = 1'b1;
        ctrl.gra      = 1'b1;
        ctrl.r_in     = 1'b1;
      end
      LD5, ST5: begin
        ctrl.zlow_out = 1'b1;
        ctrl.mar_in   = 1'b1;
      end
      LD6: begin
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        ctrl.mdr_read = MDR_MEM;
      end
      LD7: begin
        ctrl.mdr_out = 1'b1;
        ctrl.gra     = 1'b1;
        ctrl.r_in    = 1'b1;
      end
      ST6: begin
        ctrl.gra      = 1'b1;
        ctrl.ba_out   = 1'b1;
        ctrl.mdr_in   = 1'b1;
        ctrl.mdr_read = MDR_BUS;
      end
      ST7: ctrl.write = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch/decode plus LD, LDI and ST sequences,
// with sticky halted/illegal status flags.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zlowin,
  output logic        PCin,
  output logic        MDRin,
  output logic        read,
  output logic        write,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPc,
  output logic        Cout,
  output logic        BAout,
  output logic        Rin,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic [4:0]  present_state,
  output logic        halted,
  output logic        illegal
);

  state_t   state, state_nxt;
  logic     illegal_set;
  logic     unused_ir_bits;
  logic [4:0] opcode;
  cu_ctrl_t ctrl;

  assign opcode = IR[31:27];
  // Only the opcode field matters to sequencing; operand fields go to the datapath
  assign unused_ir_bits = ^IR[26:0];

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    case (state)
      RST:  state_nxt = run ? F0 : RST;
      F0:   state_nxt = F1;
      F1:   state_nxt = F2;
      F2: begin
        case (opcode)
          OP_LD:   state_nxt = LD3;
          OP_LDI:  state_nxt = LDI3;
          OP_ST:   state_nxt = ST3;
          OP_HALT: state_nxt = HALT;
          default: begin
            state_nxt   = F0;
            illegal_set = 1'b1;
          end
        endcase
      end
      LDI3: state_nxt = LDI4;
      LDI4: state_nxt = LDI5;
      LD3:  state_nxt = LD4;
      LD4:  state_nxt = LD5;
      LD5:  state_nxt = LD6;
      LD6:  state_nxt = LD7;
      ST3:  state_nxt = ST4;
      ST4:  state_nxt = ST5;
      ST5:  state_nxt = ST6;
      ST6:  state_nxt = ST7;
      LDI5, LD7, ST7: state_nxt = run ? F0 : RST;
      HALT: state_nxt = HALT;
      default: state_nxt = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RST;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == HALT) halted <= 1'b1;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  cu_out_decode u_out_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign present_state = state;
  assign PCout    = ctrl.pc_out;
  assign Zlowout  = ctrl.zlow_out;
  assign MDRout   = ctrl.mdr_out;
  assign MARin    = ctrl.mar_in;
  assign Zlowin   = ctrl.zlow_in;
  assign PCin     = ctrl.pc_in;
  assign MDRin    = ctrl.mdr_in;
  assign read     = ctrl.read;
  assign write    = ctrl.write;
  assign IRin     = ctrl.ir_in;
  assign Yin      = ctrl.y_in;
  assign IncPc    = ctrl.inc_pc;
  assign Cout     = ctrl.c_out;
  assign BAout    = ctrl.ba_out;
  assign Rin      = ctrl.r_in;
  assign Rout     = ctrl.r_out;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign mdr_read = ctrl.mdr_read;
  assign control  = ctrl.control;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus random run/reset/IR traffic
// checked every cycle against an instruction-level reference model.
module tb_control_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, read, write, IRin;
  logic Yin, IncPc, Cout, BAout, Rin, Rout, Gra, Grb, Grc;
  logic [1:0] mdr_read;
  logic [3:0] control;
  logic [4:0] present_state;
  logic       halted, illegal;

  control_unit dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin), .read(read), .write(write),
    .IRin(IRin), .Yin(Yin), .IncPc(IncPc), .Cout(Cout), .BAout(BAout),
    .Rin(Rin), .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .mdr_read(mdr_read), .control(control), .present_state(present_state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int B_PCOUT = 0, B_ZLOWOUT = 1, B_MDROUT = 2, B_MARIN = 3, B_ZLOWIN = 4;
  localparam int B_PCIN = 5, B_MDRIN = 6, B_READ = 7, B_WRITE = 8, B_IRIN = 9;
  localparam int B_YIN = 10, B_INCPC = 11, B_COUT = 12, B_BAOUT = 13, B_RIN = 14;
  localparam int B_GRA = 16, B_GRB = 17;

  localparam logic [31:0] IR_LDI  = 32'h0880_0000;
  localparam logic [31:0] IR_LD   = 32'h0000_0055;
  localparam logic [31:0] IR_ST   = 32'h1000_005A;
  localparam logic [31:0] IR_ILL  = 32'h3800_0000;
  localparam logic [31:0] IR_HALT = 32'hF800_0000;

  typedef struct packed {
    logic [18:0] en;
    logic [1:0]  mdr;
    logic [3:0]  ctl;
  } exp_t;

  logic [18:0] obs_en;
  logic [4:0]  obs_bus;
  assign obs_en  = {Grc, Grb, Gra, Rout, Rin, BAout, Cout, IncPc, Yin, IRin,
                    write, read, MDRin, PCin, Zlowin, MARin, MDRout, Zlowout, PCout};
  assign obs_bus = {Cout, BAout, MDRout, Zlowout, PCout};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected enables per state, written straight from the state descriptions
  function automatic exp_t exp_out(input state_t s);
    exp_t e;
    e = '0;
    case (s)
      F0:   begin e.en[B_PCOUT] = 1; e.en[B_MARIN] = 1; e.en[B_INCPC] = 1; e.en[B_ZLOWIN] = 1; end
      F1:   begin e.en[B_ZLOWOUT] = 1; e.en[B_PCIN] = 1; e.en[B_READ] = 1; e.en[B_MDRIN] = 1; e.mdr = 2'b01; end
      F2:   begin e.en[B_MDROUT] = 1; e.en[B_IRIN] = 1; end
      LD3, LDI3, ST3: begin e.en[B_GRB] = 1; e.en[B_BAOUT] = 1; e.en[B_YIN] = 1; end
      LD4, LDI4, ST4: begin e.en[B_COUT] = 1; e.en[B_ZLOWIN] = 1; e.ctl = 4'd2; end
      LDI5: begin e.en[B_ZLOWOUT] = 1; e.en[B_GRA] = 1; e.en[B_RIN] = 1; end
      LD5, ST5: begin e.en[B_ZLOWOUT] = 1; e.en[B_MARIN] = 1; end
      LD6:  begin e.en[B_READ] = 1; e.en[B_MDRIN] = 1; e.mdr = 2'b01; end
      LD7:  begin e.en[B_MDROUT] = 1; e.en[B_GRA] = 1; e.en[B_RIN] = 1; end
      ST6:  begin e.en[B_GRA] = 1; e.en[B_BAOUT] = 1; e.en[B_MDRIN] = 1; end
      ST7:  e.en[B_WRITE] = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // Reference model: current step plus a queue of the steps still owed
  state_t m_state = RST;
  state_t m_q[$];
  bit     m_halted = 0;
  bit     m_illegal = 0;

  task automatic model_step(input bit r, input bit rn, input logic [31:0] ir);
    logic [4:0] op;
    op = ir[31:27];
    if (!r) begin
      m_state = RST; m_q.delete(); m_halted = 0; m_illegal = 0;
      return;
    end
    if (m_state == HALT) return;
    if (m_state == F2) begin
      if (op == 5'd0)       m_q = '{LD3, LD4, LD5, LD6, LD7};
      else if (op == 5'd1)  m_q = '{LDI3, LDI4, LDI5};
      else if (op == 5'd2)  m_q = '{ST3, ST4, ST5, ST6, ST7};
      else if (op == 5'd31) begin m_state = HALT; m_halted = 1; return; end
      else begin m_illegal = 1; m_state = F0; m_q = '{F1, F2}; return; end
    end
    if (m_q.size() != 0) m_state = m_q.pop_front();
    else if (rn) begin m_state = F0; m_q = '{F1, F2}; end
    else m_state = RST;
  endtask

  task automatic compare_all();
    exp_t e;
    e = exp_out(m_state);
    check_val("state", present_state, m_state);
    check_val("enables", obs_en, e.en);
    check_val("mdr_read", mdr_read, e.mdr);
    check_val("control", control, e.ctl);
    check_val("halted", halted, m_halted);
    check_val("illegal", illegal, m_illegal);
    check_val("rw_excl", read & write, 0);
    check_val("bus_le1", $countones(obs_bus) <= 1, 1);
  endtask

  // Inputs applied just after a falling edge; outputs sampled at the next falling edge
  task automatic cycle(input bit r, input bit rn, input logic [31:0] ir);
    reset = r; run = rn; IR = ir;
    model_step(r, rn, ir);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // From RST, execute one instruction with run=1; returns cycles F0..last step
  task automatic run_instr(input logic [31:0] ir, output int lat);
    int n;
    cycle(1, 1, ir);
    check_val("instr_f0", present_state, F0);
    n = 1;
    do begin
      cycle(1, 1, ir);
      n++;
      if (present_state == LD6) begin
        check_val("ld6_read", read, 1);
        check_val("ld6_mdr", mdr_read, 2'b01);
      end
      if (present_state == LD7) check_val("ld7_rin", Rin, 1);
      if (present_state >= ST3 && present_state <= ST7) check_val("st_no_read", read, 0);
      if (present_state == ST7) check_val("st7_only_write", obs_en, 19'h00100);
    end while (present_state != F0 && n < 20);
    lat = n - 1;
  endtask

  initial begin
    int lat;
    state_t ldi_seq[7];
    reset = 0; run = 0; IR = '0;
    @(negedge clk);
    cycle(0, 0, '0);
    check_val("rst_state", present_state, 0);
    check_val("rst_outputs", obs_en, 0);

    // LDI sequence and its enables
    ldi_seq = '{F0, F1, F2, LDI3, LDI4, LDI5, F0};
    for (int unsigned i = 0; i < 7; i++) begin
      cycle(1, 1, IR_LDI);
      check_val("ldi_seq", present_state, ldi_seq[i]);
      if (i == 5) check_val("ldi5_gra_rin_zlow", {Gra, Rin, Zlowout}, 3'b111);
    end

    cycle(0, 0, '0);
    run_instr(IR_LDI, lat); check_val("lat_ldi", lat, 6);
    cycle(0, 0, '0);
    run_instr(IR_LD, lat);  check_val("lat_ld", lat, 8);
    cycle(0, 0, '0);
    run_instr(IR_ST, lat);  check_val("lat_st", lat, 8);

    // run dropped during LD4: instruction completes, then parks in RST
    cycle(0, 0, '0);
    for (int unsigned i = 0; i < 5; i++) cycle(1, 1, IR_LD);
    check_val("ld4_reached", present_state, LD4);
    for (int unsigned i = 0; i < 3; i++) cycle(1, 0, IR_LD);
    check_val("ld7_after_drop", present_state, LD7);
    cycle(1, 0, IR_LD); check_val("park_rst", present_state, RST);
    cycle(1, 0, IR_LD); check_val("hold_rst", present_state, RST);
    cycle(1, 1, IR_LD); check_val("resume_f0", present_state, F0);

    // reset in ST6 aborts the store before its write
    cycle(0, 0, '0);
    for (int unsigned i = 0; i < 7; i++) cycle(1, 1, IR_ST);
    check_val("st6_reached", present_state, ST6);
    cycle(0, 1, IR_ST);
    check_val("abort_state", present_state, RST);
    check_val("abort_outputs", obs_en, 0);
    cycle(0, 1, IR_ST);
    check_val("abort_no_write", write, 0);

    // illegal opcode, then HALT held until reset
    for (int unsigned i = 0; i < 4; i++) cycle(1, 1, IR_ILL);
    check_val("ill_back_f0", present_state, F0);
    check_val("ill_flag", illegal, 1);
    for (int unsigned i = 0; i < 3; i++) cycle(1, 1, IR_HALT);
    check_val("halt_state", present_state, HALT);
    for (int unsigned i = 0; i < 20; i++) cycle(1, 1'($urandom), $urandom);
    check_val("halt_hold", present_state, HALT);
    check_val("halt_flag", halted, 1);
    check_val("ill_sticky", illegal, 1);
    cycle(0, 1, IR_LD);
    check_val("halt_exit_rst", present_state, RST);
    check_val("halt_cleared", {halted, illegal}, 2'b00);
    cycle(1, 1, IR_LD);
    check_val("first_f0", present_state, F0);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      int unsigned sel;
      logic [4:0]  op;
      bit r, rn;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: op = 5'd0;
        3, 4:    op = 5'd1;
        5, 6:    op = 5'd2;
        7:       op = 5'($urandom_range(3, 30));
        8:       op = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd1;
        default: op = 5'($urandom);
      endcase
      if (m_state == HALT) r = ($urandom_range(0, 5) != 0);
      else                 r = ($urandom_range(0, 59) != 0);
      rn = ($urandom_range(0, 4) != 0);
      cycle(r, rn, {op, 27'($urandom)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
